// File: rtl/tge_pkg.sv
// Shared types and constants for the 10GbE UDP packetizer:
// FSM state encoding, header magic and the header word layout.
package tge_pkg;

  localparam int unsigned MAGIC_W = 16;
  localparam int unsigned SEQ_W   = 48;
  localparam int unsigned HDR_W   = MAGIC_W + SEQ_W;

  localparam logic [MAGIC_W-1:0] HEADER_MAGIC = 16'hA5C3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    GAP     = 2'd2
  } state_t;

  // Header word: magic in [63:48], sequence number in [47:0]
  typedef struct packed {
    logic [MAGIC_W-1:0] magic;
    logic [SEQ_W-1:0]   seq;
  } header_t;

  function automatic header_t make_header(input logic [SEQ_W-1:0] seq);
    header_t h;
    h.magic = HEADER_MAGIC;
    h.seq   = seq;
    return h;
  endfunction

endpackage

// File: rtl/tge_packetizer.sv
// Frames the 64-bit serializer stream into fixed-length UDP payloads:
// one header word, PAYLOAD_WORDS data words with EOF on the last, then a gap.
module tge_packetizer
  import tge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned PAYLOAD_WORDS = 128,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned SEQ_WIDTH     = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_tx_afull,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_eof,
  output logic [SEQ_WIDTH-1:0]  o_seq
);

  localparam int unsigned WCW = $clog2(PAYLOAD_WORDS);
  localparam int unsigned GCW = $clog2(GAP_CYCLES + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(PAYLOAD_WORDS - 1);
  localparam logic [GCW-1:0] LAST_GAP  = GCW'(GAP_CYCLES - 1);

  state_t               state;
  logic [WCW-1:0]       word_cnt;
  logic [GCW-1:0]       gap_cnt;
  logic [SEQ_WIDTH-1:0] seq;

  // Upstream may only transfer while a packet body is being streamed
  assign o_ready = ce && (state == PAYLOAD);
  assign o_seq   = seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      gap_cnt  <= '0;
      seq      <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_eof    <= 1'b0;
    end else if (ce) begin
      unique case (state)
        IDLE: begin
          o_eof <= 1'b0;
          // Start only when data is waiting and the TX core has room
          if (i_valid && !i_tx_afull) begin
            o_data   <= DATA_WIDTH'(make_header(SEQ_W'(seq)));
            o_valid  <= 1'b1;
            word_cnt <= '0;
            state    <= PAYLOAD;
          end else begin
            o_valid <= 1'b0;
          end
        end
        PAYLOAD: begin
          if (i_valid) begin
            o_data   <= i_data;
            o_valid  <= 1'b1;
            word_cnt <= word_cnt + WCW'(1);
            if (word_cnt == LAST_WORD) begin
              o_eof   <= 1'b1;
              seq     <= seq + SEQ_WIDTH'(1);
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              o_eof <= 1'b0;
            end
          end else begin
            o_valid <= 1'b0;
            o_eof   <= 1'b0;
          end
        end
        GAP: begin
          o_valid <= 1'b0;
          o_eof   <= 1'b0;
          gap_cnt <= gap_cnt + GCW'(1);
          if (gap_cnt == LAST_GAP) state <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_eof   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tge_packetizer.sv
// Scoreboard bench for tge_packetizer: accepted words are queued by the driver,
// and a monitor rebuilds the expected packet stream (header, payload, gap) from them.
module tb_tge_packetizer;
  import tge_pkg::*;

  localparam int unsigned TB_PW  = 4;
  localparam int unsigned TB_GAP = 2;

  logic        clk = 1'b0;
  logic        rst, ce, i_valid, i_tx_afull;
  logic [63:0] i_data;
  logic        o_ready, o_valid, o_eof;
  logic [63:0] o_data;
  logic [47:0] o_seq;

  always #5 clk = ~clk;

  tge_packetizer #(
    .DATA_WIDTH   (64),
    .PAYLOAD_WORDS(TB_PW),
    .GAP_CYCLES   (TB_GAP),
    .SEQ_WIDTH    (48)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_tx_afull(i_tx_afull),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_eof     (o_eof),
    .o_seq     (o_seq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Words the upstream has handed over, in order
  logic [63:0] acc_q[$];

  // Inputs as seen by the most recent clock edge
  logic last_rst = 1'b0, last_ce = 1'b0, last_valid = 1'b0, last_afull = 1'b0;
  always @(posedge clk) begin
    last_rst   <= rst;
    last_ce    <= ce;
    last_valid <= i_valid;
    last_afull <= i_tx_afull;
  end

  // Reference model state: packet framing at the stream level
  bit          in_packet = 1'b0;
  int          pos       = 0;
  int          since_eof = 1000;
  logic [47:0] mseq      = '0;
  logic [63:0] p_data    = '0;
  logic        p_valid   = 1'b0, p_eof = 1'b0;
  logic [47:0] p_seq     = '0;

  always @(negedge clk) begin
    logic [63:0] exp_word;
    bit          hdr_exp;
    bit          is_hdr;
    if (last_rst) begin
      check("rst_valid", 64'(o_valid), 64'(0));
      check("rst_eof", 64'(o_eof), 64'(0));
      check("rst_data", o_data, 64'(0));
      check("rst_seq", 64'(o_seq), 64'(0));
      in_packet = 1'b0;
      pos       = 0;
      mseq      = '0;
      since_eof = 1000;
    end else if (!last_ce) begin
      check("hold_data", o_data, p_data);
      check("hold_valid", 64'(o_valid), 64'(p_valid));
      check("hold_eof", 64'(o_eof), 64'(p_eof));
      check("hold_seq", 64'(o_seq), 64'(p_seq));
    end else begin
      if (!in_packet) since_eof++;
      hdr_exp = !in_packet && (since_eof >= int'(TB_GAP) + 1) && last_valid && !last_afull;
      is_hdr  = o_valid && !in_packet;
      check("hdr_start", 64'(is_hdr), 64'(hdr_exp));
      if (is_hdr) begin
        check("hdr_data", o_data, {HEADER_MAGIC, mseq});
        check("hdr_eof", 64'(o_eof), 64'(0));
        in_packet = 1'b1;
        pos       = 0;
      end else if (o_valid) begin
        if (acc_q.size() == 0) begin
          check("data_avail", 64'(0), 64'(1));
        end else begin
          exp_word = acc_q.pop_front();
          check("payload", o_data, exp_word);
          check("payload_eof", 64'(o_eof), 64'(pos == int'(TB_PW) - 1));
          pos++;
          if (pos == int'(TB_PW)) begin
            in_packet = 1'b0;
            mseq      = mseq + 48'd1;
            since_eof = 0;
          end
        end
      end else begin
        check("idle_eof", 64'(o_eof), 64'(0));
      end
      check("seq", 64'(o_seq), 64'(mseq));
    end
    check("ready", 64'(o_ready), 64'(ce && in_packet));
    p_data  = o_data;
    p_valid = o_valid;
    p_eof   = o_eof;
    p_seq   = o_seq;
  end

  // Upstream model: holds the current word until a transfer happens
  logic [63:0] next_word = '0;
  bit          rand_data = 1'b0;

  task automatic cyc(input logic v, input logic af, input logic c, input logic r);
    @(posedge clk);
    #1;
    i_valid    = v;
    i_tx_afull = af;
    ce         = c;
    rst        = r;
    i_data     = next_word;
    #1;
    if (!r && v && o_ready) begin
      acc_q.push_back(next_word);
      next_word = rand_data ? {$urandom(), $urandom()} : next_word + 64'd1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    ce         = 1'b1;
    i_valid    = 1'b0;
    i_tx_afull = 1'b0;
    i_data     = '0;
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);

    // Back-to-back words 0..7: two packets at minimum spacing
    repeat (12) cyc(1, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check("p1_seq", 64'(o_seq), 64'(2));
    check("p1_words", next_word, 64'(8));
    repeat (6) cyc(0, 0, 1, 0);

    // Valid toggling every cycle mid-packet
    for (int i = 0; i < 24; i++) cyc(logic'(i % 2 == 0), 0, 1, 0);
    repeat (8) cyc(0, 0, 1, 0);

    // Almost-full blocks packet start, but not an ongoing packet
    repeat (5) cyc(1, 1, 1, 0);
    check("afull_noready", 64'(o_ready), 64'(0));
    check("afull_novalid", 64'(o_valid), 64'(0));
    cyc(1, 0, 1, 0);
    repeat (2) cyc(1, 0, 1, 0);
    repeat (6) cyc(1, 1, 1, 0);
    repeat (8) cyc(0, 0, 1, 0);

    // Clock enable low for three cycles inside the payload
    repeat (3) cyc(1, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0);
    repeat (6) cyc(1, 0, 1, 0);
    repeat (8) cyc(0, 0, 1, 0);

    // Reset after two data words abandons the packet
    repeat (3) cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 1);
    repeat (8) cyc(1, 0, 1, 0);
    repeat (8) cyc(0, 0, 1, 0);

    // Sequence counter wrap
    @(posedge clk);
    #3;
    force dut.seq = 48'hFFFF_FFFF_FFFF;
    mseq = 48'hFFFF_FFFF_FFFF;
    cyc(0, 0, 1, 0);
    #1;
    release dut.seq;
    cyc(0, 0, 1, 0);
    repeat (8) cyc(1, 0, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);
    check("wrap_seq", 64'(o_seq), 64'(0));
    repeat (6) cyc(0, 0, 1, 0);

    // Randomised traffic, back-pressure, clock enable and occasional reset
    rand_data = 1'b1;
    next_word = {$urandom(), $urandom()};
    for (int i = 0; i < 1500; i++) begin
      cyc(logic'($urandom_range(3, 0) != 0), logic'($urandom_range(3, 0) == 0),
          logic'($urandom_range(7, 0) != 0), logic'($urandom_range(199, 0) == 0));
    end
    repeat (20) cyc(0, 0, 1, 0);
    check("drain_empty", 64'(acc_q.size()), 64'(0));
    check("drain_idle", 64'(in_packet), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
